uart_tx: RTL and testbench

//   UART transmitter: serialises one parallel byte per request onto the tx line.

---
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter. Sends one frame per accepted tx_start: a start bit (0),
// DBIT data bits LSB first, an optional parity bit, then the stop interval (1).
// Bit timing is driven by the shared 16x-oversample s_tick strobe, so the
// transmitter and the receiver run from the same baud source.
module uart_tx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16,  // s_ticks in the stop interval (16/24/32)
  parameter int PARITY  = 0    // 0 none, 1 even, 2 odd
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam bit         P_INIT    = (PARITY == 2);  // odd parity starts the XOR at 1
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic [4:0] S_LAST    = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;    // ticks within the current bit
  logic [2:0] n_q, n_d;    // data bit index
  logic [7:0] b_q, b_d;    // latched byte, shifted out LSB first
  logic       p_q, p_d;    // running parity of bits already sent
  logic       tx_q, tx_d;

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; everything holds unless s_tick advances the bit timer.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    p_d          = p_q;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          p_d     = P_INIT;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            p_d = p_q ^ b_q[0];
            b_d = {1'b0, b_q[7:1]};
            if (n_q == N_LAST) state_d = HAS_PAR ? PAR : STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d      = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the state being entered, so tx is registered yet moves on the same edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PAR:     tx_d = p_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different DBIT/PARITY/SB_TICK share
// clk, reset_n and s_tick. Each frame is checked tick by tick against a model
// that derives the expected line level from the byte and the frame layout.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic [3:0] tx_start, busy, done, txl;
  logic [7:0] din [4];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (.clk(clk), .reset_n(reset_n),
    .tx_start(tx_start[0]), .s_tick(s_tick), .din(din[0]), .tx_busy(busy[0]),
    .tx_done_tick(done[0]), .tx(txl[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (.clk(clk), .reset_n(reset_n),
    .tx_start(tx_start[1]), .s_tick(s_tick), .din(din[1]), .tx_busy(busy[1]),
    .tx_done_tick(done[1]), .tx(txl[1]));
  uart_tx #(.DBIT(8), .SB_TICK(24), .PARITY(2)) u2 (.clk(clk), .reset_n(reset_n),
    .tx_start(tx_start[2]), .s_tick(s_tick), .din(din[2]), .tx_busy(busy[2]),
    .tx_done_tick(done[2]), .tx(txl[2]));
  uart_tx #(.DBIT(7), .SB_TICK(16), .PARITY(0)) u3 (.clk(clk), .reset_n(reset_n),
    .tx_start(tx_start[3]), .s_tick(s_tick), .din(din[3]), .tx_busy(busy[3]),
    .tx_done_tick(done[3]), .tx(txl[3]));

  // ---- reference model -------------------------------------------------
  function automatic int dbit_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 2) ? 24 : 16;
  endfunction

  function automatic int frame_len(input int i);
    return 16 * (1 + dbit_of(i) + ((par_of(i) != 0) ? 1 : 0)) + sb_of(i);
  endfunction

  // Expected line level during bit slot pos (0 = start bit).
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int pos);
    int ones;
    int dv;
    dv = int'(d);
    if (pos == 0) return 1'b0;
    if (pos <= dbit_of(i)) return logic'((dv >> (pos - 1)) % 2);
    if (par_of(i) != 0 && pos == dbit_of(i) + 1) begin
      ones = 0;
      for (int j = 0; j < dbit_of(i); j++) ones += (dv >> j) % 2;
      return logic'((ones % 2) ^ ((par_of(i) == 2) ? 1 : 0));
    end
    return 1'b1;
  endfunction

  // ---- checking helpers --------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive s_tick for one clk from a negedge; capture done before the edge, return at next negedge.
  task automatic step(input int i, input logic tk, output logic dn);
    s_tick = tk;
    #1 dn = done[i];
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  // Send one frame on instance i and check it against the model.
  // repulse_k: re-raise tx_start with other data before tick k (-1 = never).
  // abort_k:   pull reset after tick k and return (-1 = never).
  task automatic send(input int i, input logic [7:0] d, input bit hold,
                      input int repulse_k, input int abort_k,
                      output int done_at, output logic par_seen);
    int   total, mism, dcount, gaps;
    logic dn, e;
    total    = frame_len(i);
    mism     = 0;
    dcount   = 0;
    done_at  = -1;
    par_seen = 1'bx;
    din[i]      = d;
    tx_start[i] = 1'b1;
    step(i, 1'b0, dn);
    if (!hold) tx_start[i] = 1'b0;
    din[i] = 8'($urandom);
    chk("start_latency", {30'd0, busy[i], txl[i]}, 32'b10);
    for (int k = 0; k < total; k++) begin
      e = exp_bit(i, d, k / 16);
      if (k == repulse_k) begin
        din[i]      = 8'hAA;
        tx_start[i] = 1'b1;
        step(i, 1'b0, dn);
        tx_start[i] = hold;
        if (dn) dcount++;
      end
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        step(i, 1'b0, dn);
        if (dn) dcount++;
        if (txl[i] !== e || busy[i] !== 1'b1) mism++;
      end
      if (txl[i] !== e || busy[i] !== 1'b1) mism++;
      if (par_of(i) != 0 && k == 16 * (dbit_of(i) + 1) + 8) par_seen = txl[i];
      step(i, 1'b1, dn);
      if (dn) begin
        dcount++;
        if (done_at < 0) done_at = k + 1;
      end
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1 chk("abort_immediate", {30'd0, busy[i], txl[i]}, 32'b01);
        @(negedge clk);
        @(negedge clk);
        reset_n     = 1'b1;
        tx_start[i] = 1'b0;
        return;
      end
    end
    chk("frame_bits_mismatches", mism, 0);
    chk("done_count", dcount, 1);
    chk("end_idle", {30'd0, busy[i], txl[i]}, 32'b01);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] d;
    int         exp_par;  // -1 when the instance has no parity bit
    int         exp_len;  // s_ticks from acceptance to tx_done_tick
  } vec_t;

  vec_t tbl [7];

  initial begin
    int   da, cnt, ri;
    logic ps, dn;
    logic [7:0] rd;

    tbl[0] = '{0, 8'h55, -1, 160};  // plain 8N1
    tbl[1] = '{1, 8'h07,  1, 176};  // even parity, three ones
    tbl[2] = '{2, 8'h07,  0, 184};  // odd parity, 1.5 stop bits
    tbl[3] = '{1, 8'h00,  0, 176};  // even parity of zero
    tbl[4] = '{2, 8'h00,  1, 184};  // odd parity of zero
    tbl[5] = '{3, 8'hFF, -1, 144};  // 7 data bits, bit 7 dropped
    tbl[6] = '{3, 8'h80, -1, 144};  // only the ignored bit set

    reset_n  = 1'b0;
    s_tick   = 1'b0;
    tx_start = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    @(negedge clk);
    chk("reset_state", {20'd0, busy, done, txl}, {20'd0, 4'h0, 4'h0, 4'hF});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Ticks with no request must not start anything.
    for (int t = 0; t < 5; t++) step(0, 1'b1, dn);
    chk("idle_no_start", {24'd0, busy, txl}, {24'd0, 4'h0, 4'hF});

    foreach (tbl[v]) begin
      send(tbl[v].dut, tbl[v].d, 1'b0, -1, -1, da, ps);
      chk("frame_len", da, tbl[v].exp_len);
      if (tbl[v].exp_par >= 0) chk("parity_bit", {31'd0, ps}, tbl[v].exp_par);
    end

    // Re-request mid-frame is ignored.
    send(0, 8'h55, 1'b0, 16 * 3 + 4, -1, da, ps);
    chk("repulse_len", da, 160);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      step(0, 1'b1, dn);
      if (dn) cnt++;
    end
    chk("repulse_no_second", {cnt[30:0], busy[0]}, 0);

    // Back-to-back frames with tx_start held high.
    send(0, 8'h3C, 1'b1, -1, -1, da, ps);
    chk("b2b_first_len", da, 160);
    send(0, 8'hC3, 1'b0, -1, -1, da, ps);
    chk("b2b_second_len", da, 160);

    // Reset during data bit 3, then a clean frame.
    send(0, 8'hA5, 1'b0, -1, 16 * 4 + 5, da, ps);
    chk("post_reset_idle", {30'd0, busy[0], txl[0]}, 32'b01);
    send(0, 8'h81, 1'b0, -1, -1, da, ps);
    chk("post_reset_len", da, 160);

    // Random bytes on random instances.
    for (int r = 0; r < 10; r++) begin
      ri = $urandom_range(0, 3);
      rd = 8'($urandom);
      send(ri, rd, 1'b0, -1, -1, da, ps);
      chk("rand_len", da, frame_len(ri));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
